// File: rtl/cc_req_driver.sv
// cc_req_driver: host-facing initiator for the CC coordinate-calculation interface.
// Takes one command (mode + NPTS points), streams it to CC as NPTS in_valid beats,
// then relays the CC result burst back to the host through a one-beat hold register
// so the final beat can be tagged with rsp_last.
module cc_req_driver #(
    parameter int unsigned W       = 8,
    parameter int unsigned NPTS    = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [2*W*NPTS-1:0]   cmd_pts,
    output logic                  in_valid,
    output logic [1:0]            mode,
    output logic [W-1:0]          xi,
    output logic [W-1:0]          yi,
    input  logic                  out_valid,
    input  logic [W-1:0]          xo,
    input  logic [W-1:0]          yo,
    output logic                  rsp_valid,
    output logic [W-1:0]          rsp_x,
    output logic [W-1:0]          rsp_y,
    output logic                  rsp_last,
    output logic                  rsp_tmo,
    output logic                  proto_err
);

    localparam int unsigned PTS_W  = 2 * W * NPTS;
    localparam int unsigned BEAT_W = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NPTS - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_RECV = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [PTS_W-1:0]    pts_q, pts_d;
    logic [W-1:0]        hold_x_q, hold_x_d;
    logic [W-1:0]        hold_y_q, hold_y_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                in_valid_q, in_valid_d;
    logic [1:0]          mode_q, mode_d;
    logic [W-1:0]        xi_q, xi_d;
    logic [W-1:0]        yi_q, yi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [W-1:0]        rsp_x_q, rsp_x_d;
    logic [W-1:0]        rsp_y_q, rsp_y_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_tmo_q, rsp_tmo_d;
    logic                proto_err_q, proto_err_d;

    logic                accept;
    logic [PTS_W-1:0]    pts_src;
    logic [W-1:0]        pt_x [NPTS];
    logic [W-1:0]        pt_y [NPTS];

    // Command handshake: only an idle driver that is advertising ready takes a command
    assign accept = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;

    // Beat 0 is launched in the accept cycle, before the point latch has loaded
    assign pts_src = accept ? cmd_pts : pts_q;

    // Unpack the point vector: point k has x in the low half, y in the high half
    for (genvar k = 0; k < NPTS; k++) begin : g_pt
        assign pt_x[k] = pts_src[2*W*k +: W];
        assign pt_y[k] = pts_src[2*W*k + W +: W];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic: beat counter walks SEND, wait counter bounds WAIT
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND;
                    beat_d  = '0;
                end
            end
            S_SEND: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (out_valid) begin
                    state_d = S_RECV;
                end else if (wcnt_q == WCNT_MAX) begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (!out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, all registered below
    always_comb begin
        cmd_ready_d = 1'b0;
        in_valid_d  = 1'b0;
        mode_d      = 2'b00;
        xi_d        = '0;
        yi_d        = '0;
        rsp_valid_d = 1'b0;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_last_d  = 1'b0;
        rsp_tmo_d   = 1'b0;
        proto_err_d = proto_err_q;
        pts_d       = pts_q;
        hold_x_d    = hold_x_q;
        hold_y_d    = hold_y_q;

        // Ready only once the FSM has spent a full cycle back in IDLE
        cmd_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);

        if (accept) begin
            pts_d = cmd_pts;
        end

        // Drive the beat the FSM is about to be in; mode only rides on beat 0
        if (state_d == S_SEND) begin
            in_valid_d = 1'b1;
            xi_d       = pt_x[beat_d];
            yi_d       = pt_y[beat_d];
            if (accept) begin
                mode_d = cmd_mode;
            end
        end

        case (state_q)
            S_IDLE, S_SEND: begin
                if (out_valid) begin
                    proto_err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (out_valid) begin
                    hold_x_d = xo;
                    hold_y_d = yo;
                end else if (wcnt_q == WCNT_MAX) begin
                    rsp_tmo_d = 1'b1;
                end
            end
            S_RECV: begin
                // Emit the held beat; it is the last one if the burst just ended
                rsp_valid_d = 1'b1;
                rsp_x_d     = hold_x_q;
                rsp_y_d     = hold_y_q;
                rsp_last_d  = !out_valid;
                if (out_valid) begin
                    hold_x_d = xo;
                    hold_y_d = yo;
                end
            end
            default: ;
        endcase
    end

    // Output, point-latch and hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q <= 1'b0;
            in_valid_q  <= 1'b0;
            mode_q      <= 2'b00;
            xi_q        <= '0;
            yi_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_last_q  <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            proto_err_q <= 1'b0;
            pts_q       <= '0;
            hold_x_q    <= '0;
            hold_y_q    <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            in_valid_q  <= in_valid_d;
            mode_q      <= mode_d;
            xi_q        <= xi_d;
            yi_q        <= yi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_last_q  <= rsp_last_d;
            rsp_tmo_q   <= rsp_tmo_d;
            proto_err_q <= proto_err_d;
            pts_q       <= pts_d;
            hold_x_q    <= hold_x_d;
            hold_y_q    <= hold_y_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_valid  = in_valid_q;
    assign mode      = mode_q;
    assign xi        = xi_q;
    assign yi        = yi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cc_req_driver.sv
// tb_cc_req_driver: directed + randomized bench for cc_req_driver.
// Inputs are driven and outputs sampled on the falling edge; the expected
// cycle timeline is computed from the command/reply parameters.
module tb_cc_req_driver;

    localparam int unsigned W       = 8;
    localparam int unsigned NPTS    = 4;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned PTS_W   = 2 * W * NPTS;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_mode;
    logic [PTS_W-1:0]   cmd_pts;
    logic               in_valid;
    logic [1:0]         mode;
    logic [W-1:0]       xi;
    logic [W-1:0]       yi;
    logic               out_valid;
    logic [W-1:0]       xo;
    logic [W-1:0]       yo;
    logic               rsp_valid;
    logic [W-1:0]       rsp_x;
    logic [W-1:0]       rsp_y;
    logic               rsp_last;
    logic               rsp_tmo;
    logic               proto_err;

    cc_req_driver #(.W(W), .NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_pts   (cmd_pts),
        .in_valid  (in_valid),
        .mode      (mode),
        .xi        (xi),
        .yi        (yi),
        .out_valid (out_valid),
        .xo        (xo),
        .yo        (yo),
        .rsp_valid (rsp_valid),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_last  (rsp_last),
        .rsp_tmo   (rsp_tmo),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: command points, CC reply beats, expected hold and sticky error
    logic [W-1:0] px [NPTS];
    logic [W-1:0] py [NPTS];
    logic [W-1:0] bx [16];
    logic [W-1:0] by [16];
    logic [W-1:0] exp_hx;
    logic [W-1:0] exp_hy;
    logic         exp_perr;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ready, input logic e_inv,
                             input logic [1:0] e_mode, input logic [W-1:0] e_xi,
                             input logic [W-1:0] e_yi, input logic e_rv,
                             input logic e_last, input logic e_tmo);
        chk($sformatf("%s.cmd_ready", tag), 32'(cmd_ready), 32'(e_ready));
        chk($sformatf("%s.in_valid", tag),  32'(in_valid),  32'(e_inv));
        chk($sformatf("%s.mode", tag),      32'(mode),      32'(e_mode));
        chk($sformatf("%s.xi", tag),        32'(xi),        32'(e_xi));
        chk($sformatf("%s.yi", tag),        32'(yi),        32'(e_yi));
        chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(e_rv));
        chk($sformatf("%s.rsp_last", tag),  32'(rsp_last),  32'(e_last));
        chk($sformatf("%s.rsp_tmo", tag),   32'(rsp_tmo),   32'(e_tmo));
        chk($sformatf("%s.rsp_x", tag),     32'(rsp_x),     32'(exp_hx));
        chk($sformatf("%s.rsp_y", tag),     32'(rsp_y),     32'(exp_hy));
        chk($sformatf("%s.proto_err", tag), 32'(proto_err), 32'(exp_perr));
    endtask

    // glitch_beat: -2 none, -1 out_valid during the accept (IDLE) cycle, k during SEND beat k
    // abort_beat: -1 none, k asserts rst during SEND beat k
    task automatic send_cmd(input string tag, input logic [1:0] m,
                            input int glitch_beat, input int abort_beat);
        logic [PTS_W-1:0] pts;
        int waited;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk($sformatf("%s.ready_wait", tag), 32'(cmd_ready), 32'd1);
        pts = '0;
        for (int k = 0; k < NPTS; k++) begin
            pts[2*W*k +: W]     = px[k];
            pts[2*W*k + W +: W] = py[k];
        end
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_pts   = pts;
        out_valid = (glitch_beat == -1);
        xo        = W'($urandom());
        yo        = W'($urandom());
        if (glitch_beat == -1) exp_perr = 1'b1;
        tick();
        // Scramble the command inputs: the driver must work from its latched copy
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom());
        cmd_pts   = PTS_W'({$urandom(), $urandom()});
        for (int k = 0; k < NPTS; k++) begin
            check_all($sformatf("%s.beat%0d", tag, k), 1'b0, 1'b1,
                      (k == 0) ? m : 2'b00, px[k], py[k], 1'b0, 1'b0, 1'b0);
            if (k == abort_beat) begin
                rst       = 1'b1;
                out_valid = 1'b0;
                tick();
                exp_perr = 1'b0;
                exp_hx   = '0;
                exp_hy   = '0;
                check_all($sformatf("%s.abort", tag), 1'b0, 1'b0, 2'b00, '0, '0,
                          1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                tick();
                check_all($sformatf("%s.abort_rel", tag), 1'b1, 1'b0, 2'b00, '0, '0,
                          1'b0, 1'b0, 1'b0);
                return;
            end
            out_valid = (k == glitch_beat);
            if (k == glitch_beat) exp_perr = 1'b1;
            tick();
        end
        out_valid = 1'b0;
    endtask

    // CC answers d cycles into WAIT with n back-to-back beats (bx/by).
    // Each beat is captured into the hold register, then emitted a cycle later,
    // so host beat i appears two cycles after CC beat i; ready follows rsp_last.
    task automatic reply(input string tag, input int d, input int n);
        for (int t = 0; t <= d + n + 2; t++) begin
            logic e_rv;
            logic e_last;
            logic e_ready;
            e_rv    = (t >= d + 2) && (t < d + n + 2);
            e_last  = (t == d + n + 1);
            e_ready = (t == d + n + 2);
            if (e_rv) begin
                exp_hx = bx[t - d - 2];
                exp_hy = by[t - d - 2];
            end
            check_all($sformatf("%s.t%0d", tag, t), e_ready, 1'b0, 2'b00, '0, '0,
                      e_rv, e_last, 1'b0);
            if (t >= d && t < d + n) begin
                out_valid = 1'b1;
                xo        = bx[t - d];
                yo        = by[t - d];
            end else begin
                out_valid = 1'b0;
                xo        = W'($urandom());
                yo        = W'($urandom());
            end
            if (t < d + n + 2) tick();
        end
    endtask

    // Silent CC: in_valid falls at the edge ending the last beat, rsp_tmo rises
    // TIMEOUT edges later, and ready returns one cycle after the pulse.
    task automatic silent(input string tag);
        for (int t = 0; t <= int'(TIMEOUT) + 1; t++) begin
            check_all($sformatf("%s.t%0d", tag, t), (t == int'(TIMEOUT) + 1), 1'b0, 2'b00,
                      '0, '0, 1'b0, 1'b0, (t == int'(TIMEOUT)));
            out_valid = 1'b0;
            if (t <= int'(TIMEOUT)) tick();
        end
    endtask

    task automatic set_s2_points();
        px[0] = W'(0);  py[0] = W'(0);
        px[1] = W'(4);  py[1] = W'(0);
        px[2] = W'(0);  py[2] = W'(3);
        px[3] = W'(-2); py[3] = W'(-2);
        bx[0] = W'(1);  by[0] = W'(0);
    endtask

    task automatic rand_points();
        for (int k = 0; k < NPTS; k++) begin
            px[k] = W'($urandom());
            py[k] = W'($urandom());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_pts   = '0;
        out_valid = 1'b0;
        xo        = '0;
        yo        = '0;
        exp_hx    = '0;
        exp_hy    = '0;
        exp_perr  = 1'b0;

        // Reset held two cycles, then ready on the first cycle after release
        tick();
        check_all("reset0", 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("reset1", 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("reset_rel", 1'b1, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

        // Mode 1 fixed points, single-beat reply (1,0)
        set_s2_points();
        send_cmd("s2", 2'd1, -2, -1);
        reply("s2", 0, 1);

        // Mode 0, three-beat reply
        rand_points();
        bx[0] = W'(-1); by[0] = W'(2);
        bx[1] = W'(0);  by[1] = W'(2);
        bx[2] = W'(1);  by[2] = W'(2);
        send_cmd("s3", 2'd0, -2, -1);
        reply("s3", 2, 3);

        // CC never answers
        rand_points();
        send_cmd("s4", 2'd2, -2, -1);
        silent("s4");

        // Stray out_valid on SEND beat 2: sticky error, command unaffected
        rand_points();
        bx[0] = W'($urandom()); by[0] = W'($urandom());
        bx[1] = W'($urandom()); by[1] = W'($urandom());
        send_cmd("s5", 2'd3, 2, -1);
        reply("s5", 1, 2);

        // Reset during SEND beat 1, then a clean repeat of the first command
        rand_points();
        send_cmd("s6", 2'd1, -2, 1);
        set_s2_points();
        send_cmd("s6r", 2'd1, -2, -1);
        reply("s6r", 0, 1);

        // Randomized commands with occasional stray out_valid in IDLE or SEND
        for (int it = 0; it < 10; it++) begin
            logic [1:0] m;
            int g;
            int d;
            int n;
            m = 2'($urandom_range(0, 3));
            rand_points();
            if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, NPTS)) - 1;
            else g = -2;
            d = int'($urandom_range(0, 8));
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                bx[i] = W'($urandom());
                by[i] = W'($urandom());
            end
            send_cmd($sformatf("r%0d", it), m, g, -1);
            reply($sformatf("r%0d", it), d, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
